// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, fixed-latency unified memory between the RV32I
// instruction-fetch path and the load/store path.
//
// Handshake: a requester raises req and holds its request fields stable.
// The transfer happens in the cycle where req && ready are both high. ready is
// only ever high in IDLE, for exactly one port, and never while rst is high.
// A requester may drop req before ready without side effects.
//
// Sequence: IDLE -> ACCESS (MEM_LATENCY cycles of mem_en) -> RESP (one-cycle
// rvalid on the granted port) -> IDLE. When both ports request in the same
// cycle, the grant goes to the port opposite the previous grant.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   if_req/if_addr    fetch request; if_ready accept, if_rvalid/if_rdata reply
//   d_req/d_we/d_addr/d_wdata/d_be
//                     load/store request; d_ready accept, d_rvalid/d_rdata reply
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be
//                     memory strobes; mem_rdata is valid in the last ACCESS cycle
//   busy              high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_ready,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_ready,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MEM_LATENCY - 1);
   // Clears the byte offset so every memory access is word aligned.
   localparam logic [ADDR_W-1:0] ADDR_ALIGN = ~(ADDR_W'(3));

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_D  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last_grant_q, last_grant_d;
   logic                gnt_port_q, gnt_port_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

   logic                grant_if, grant_d;

   // Data wins a tie only when fetch was granted last; a lone requester
   // always wins.
   always_comb begin
      grant_d  = d_req && (!if_req || (last_grant_q == PORT_IF));
      grant_if = if_req && !grant_d;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      gnt_port_d   = gnt_port_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_ready     = 1'b0;
      d_ready      = 1'b0;
      if_rvalid    = 1'b0;
      d_rvalid     = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!rst && (grant_if || grant_d)) begin
               if_ready     = grant_if;
               d_ready      = grant_d;
               state_d      = ST_ACCESS;
               cnt_d        = '0;
               last_grant_d = grant_d ? PORT_D : PORT_IF;
               gnt_port_d   = grant_d ? PORT_D : PORT_IF;
               if (grant_d) begin
                  we_d    = d_we;
                  addr_d  = d_addr & ADDR_ALIGN;
                  wdata_d = d_we ? d_wdata : '0;
                  be_d    = d_we ? d_be : '1;
               end else begin
                  we_d    = 1'b0;
                  addr_d  = if_addr & ADDR_ALIGN;
                  wdata_d = '0;
                  be_d    = '1;
               end
            end
         end

         ST_ACCESS: begin
            mem_en = 1'b1;
            // The write strobe is a single pulse at the start of the access.
            mem_we = we_q && (cnt_q == '0);
            if (cnt_q == CNT_LAST) begin
               if (gnt_port_q == PORT_D) begin
                  d_rdata_d = we_q ? '0 : mem_rdata;
               end else begin
                  if_rdata_d = mem_rdata;
               end
               cnt_d   = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RESP: begin
            if_rvalid = (gnt_port_q == PORT_IF);
            d_rvalid  = (gnt_port_q == PORT_D);
            state_d   = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         last_grant_q <= PORT_IF;
         gnt_port_q   <= PORT_IF;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         gnt_port_q   <= gnt_port_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Three arbiter instances with MEM_LATENCY = 1, 2 and 3 (index 0, 1, 2), each
// backed by its own small memory model. Drivers issue requests and push the
// expected reply {instance, port, data} into exp_q; the monitor pops and
// compares on every rvalid pulse seen on any instance.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int N_INST = 3;
  localparam logic P_IF = 1'b0;
  localparam logic P_D  = 1'b1;

  logic        clk;
  logic        rst;
  int          cyc_cnt = 0;
  int          checks  = 0;
  int          errors  = 0;

  logic [34:0] exp_q[$];

  logic        if_req    [N_INST];
  logic [31:0] if_addr   [N_INST];
  logic        if_ready  [N_INST];
  logic        if_rvalid [N_INST];
  logic [31:0] if_rdata  [N_INST];
  logic        d_req     [N_INST];
  logic        d_we      [N_INST];
  logic [31:0] d_addr    [N_INST];
  logic [31:0] d_wdata   [N_INST];
  logic [3:0]  d_be      [N_INST];
  logic        d_ready   [N_INST];
  logic        d_rvalid  [N_INST];
  logic [31:0] d_rdata   [N_INST];
  logic        mem_en    [N_INST];
  logic        mem_we    [N_INST];
  logic [31:0] mem_addr  [N_INST];
  logic [31:0] mem_wdata [N_INST];
  logic [3:0]  mem_be    [N_INST];
  logic [31:0] mem_rdata [N_INST];
  logic        busy      [N_INST];

  function automatic logic [31:0] init_word(input int i);
    if (i == 64) return 32'hDEAD_BEEF;
    return 32'hA500_0000 | 32'(i);
  endfunction

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- DUTs and memory models ----------------
  for (genvar g = 0; g < N_INST; g++) begin : gi
    logic [31:0] mem [128];

    initial begin
      for (int i = 0; i < 128; i++) mem[i] = init_word(i);
    end

    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[g][b]) mem[mem_addr[g][8:2]][8*b +: 8] = mem_wdata[g][8*b +: 8];
        end
      end
    end

    assign mem_rdata[g] = mem[mem_addr[g][8:2]];

    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(g + 1)
    ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ready(if_ready[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_be(d_be[g]), .d_ready(d_ready[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_be(mem_be[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g])
    );
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic check_resp(input int k, input logic port, input logic [31:0] data);
    logic [34:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rvalid: inst %0d port %0d data %h, expected no reply", k, port, data);
    end else begin
      e = exp_q.pop_front();
      chk("resp_tag", {29'd0, 2'(k), port}, {29'd0, e[34:32]});
      chk("resp_data", data, e[31:0]);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int k = 0; k < N_INST; k++) begin
      if (if_rvalid[k] === 1'b1) check_resp(k, P_IF, if_rdata[k]);
      if (d_rvalid[k] === 1'b1)  check_resp(k, P_D, d_rdata[k]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issues one request on instance k and checks the cycle-level strobe
  // sequence. Returns at the start of the first IDLE cycle afterwards.
  task automatic access(input int k, input logic port, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rd,
                        output int acc_cyc);
    int   lat;
    int   waited;
    logic rdy;
    lat    = k + 1;
    waited = 0;
    if (port) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata; d_be[k] = be;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    @(negedge clk);
    rdy = port ? d_ready[k] : if_ready[k];
    while (!rdy && waited < 20) begin
      cyc();
      @(negedge clk);
      waited++;
      rdy = port ? d_ready[k] : if_ready[k];
    end
    acc_cyc = cyc_cnt;
    chk("ready", {31'd0, rdy}, 32'd1);
    chk("other_ready", {31'd0, port ? if_ready[k] : d_ready[k]}, 32'd0);
    exp_q.push_back({2'(k), port, exp_rd});
    cyc();
    if (port) d_req[k] = 1'b0; else if_req[k] = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("mem_en", {31'd0, mem_en[k]}, 32'd1);
      chk("mem_addr", mem_addr[k], addr & 32'hFFFF_FFFC);
      chk("mem_we", {31'd0, mem_we[k]}, {31'd0, we && (i == 0)});
      chk("mem_be", {28'd0, mem_be[k]}, {28'd0, we ? be : 4'hF});
      if (we) chk("mem_wdata", mem_wdata[k], wdata);
      cyc();
    end
    @(negedge clk);
    chk("mem_en_off", {31'd0, mem_en[k]}, 32'd0);
    chk("rvalid_time", {31'd0, port ? d_rvalid[k] : if_rvalid[k]}, 32'd1);
    cyc();
  endtask

  // ---------------- stimulus ----------------
  int          ac, a0, a1, a2, start_c;
  int          n, en_cnt, rdy_cnt;
  logic        gport [4];
  int          gcyc  [4];
  logic [3:0]  exp_order;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < N_INST; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0; d_be[k] = '0;
    end
    if_req[1] = 1'b1;
    d_req[1]  = 1'b1;
    repeat (3) @(posedge clk);

    // Reset state, with both requests high on instance 1.
    @(negedge clk);
    chk("rst_if_ready", {31'd0, if_ready[1]}, 32'd0);
    chk("rst_d_ready", {31'd0, d_ready[1]}, 32'd0);
    chk("rst_busy", {31'd0, busy[1]}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en[1]}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we[1]}, 32'd0);
    chk("rst_mem_addr", mem_addr[1], 32'd0);
    chk("rst_mem_wdata", mem_wdata[1], 32'd0);
    chk("rst_mem_be", {28'd0, mem_be[1]}, 32'd0);
    chk("rst_if_rdata", if_rdata[1], 32'd0);
    chk("rst_d_rdata", d_rdata[1], 32'd0);
    chk("rst_busy0", {31'd0, busy[0]}, 32'd0);
    chk("rst_busy2", {31'd0, busy[2]}, 32'd0);
    cyc();
    if_req[1] = 1'b0;
    d_req[1]  = 1'b0;
    rst       = 1'b0;

    // Single load of an unaligned address (word 0x100).
    access(1, P_D, 1'b0, 32'h102, 32'h0, 4'h0, 32'hDEAD_BEEF, ac);
    chk("load_if_rdata_idle", if_rdata[1], 32'd0);

    // Store low half, then load it back, then a fetch.
    access(1, P_D, 1'b1, 32'h40, 32'h1234_5678, 4'b0011, 32'h0, ac);
    access(1, P_D, 1'b0, 32'h40, 32'h0, 4'h0, 32'hA500_5678, ac);
    access(1, P_IF, 1'b0, 32'h104, 32'h0, 4'h0, 32'hA500_0041, ac);
    chk("d_rdata_hold", d_rdata[1], 32'hA500_5678);

    // Reset in the first ACCESS cycle of a load.
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h10;
    @(negedge clk);
    chk("rmid_ready", {31'd0, d_ready[1]}, 32'd1);
    cyc();
    d_req[1] = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("rmid_busy_access", {31'd0, busy[1]}, 32'd1);
    cyc();
    @(negedge clk);
    chk("rmid_mem_en", {31'd0, mem_en[1]}, 32'd0);
    chk("rmid_busy", {31'd0, busy[1]}, 32'd0);
    chk("rmid_d_rvalid", {31'd0, d_rvalid[1]}, 32'd0);
    chk("rmid_d_rdata", d_rdata[1], 32'd0);
    cyc();
    rst     = 1'b0;
    start_c = cyc_cnt;
    access(1, P_IF, 1'b0, 32'h20, 32'h0, 4'h0, 32'hA500_0008, ac);
    chk("rmid_first_idle_grant", ac, start_c);

    // Both requesters held from reset release: expect D, F, D, F.
    rst = 1'b1;
    if_req[1] = 1'b1; if_addr[1] = 32'h8;
    d_req[1]  = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'hC;
    exp_q.push_back({2'd1, P_D,  32'hA500_0003});
    exp_q.push_back({2'd1, P_IF, 32'hA500_0002});
    exp_q.push_back({2'd1, P_D,  32'hA500_0003});
    exp_q.push_back({2'd1, P_IF, 32'hA500_0002});
    @(negedge clk);
    chk("arb_rst_if_ready", {31'd0, if_ready[1]}, 32'd0);
    chk("arb_rst_d_ready", {31'd0, d_ready[1]}, 32'd0);
    cyc();
    rst = 1'b0;
    n   = 0;
    for (int i = 0; i < 4; i++) begin gport[i] = 1'b0; gcyc[i] = 0; end
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (if_ready[1] || d_ready[1]) begin
        chk("arb_one_ready", {31'd0, if_ready[1] & d_ready[1]}, 32'd0);
        gport[n] = d_ready[1];
        gcyc[n]  = cyc_cnt;
        n++;
      end
      cyc();
    end
    if_req[1] = 1'b0;
    d_req[1]  = 1'b0;
    exp_order = 4'b0101;
    chk("arb_grant_count", n, 32'd4);
    for (int i = 0; i < 4; i++) chk("arb_grant_port", {31'd0, gport[i]}, {31'd0, exp_order[i]});
    for (int i = 1; i < 4; i++) chk("arb_grant_spacing", gcyc[i] - gcyc[i-1], 32'd4);
    repeat (4) cyc();

    // Fetch-only stream, MEM_LATENCY = 1.
    access(0, P_IF, 1'b0, 32'h0, 32'h0, 4'h0, 32'hA500_0000, a0);
    access(0, P_IF, 1'b0, 32'h4, 32'h0, 4'h0, 32'hA500_0001, a1);
    access(0, P_IF, 1'b0, 32'h8, 32'h0, 4'h0, 32'hA500_0002, a2);
    chk("stream_spacing1", a1 - a0, 32'd3);
    chk("stream_spacing2", a2 - a1, 32'd3);

    // Data request raised while busy, withdrawn before IDLE, MEM_LATENCY = 3.
    if_req[2] = 1'b1; if_addr[2] = 32'h30;
    exp_q.push_back({2'd2, P_IF, 32'hA500_000C});
    @(negedge clk);
    chk("wd_if_ready", {31'd0, if_ready[2]}, 32'd1);
    cyc();
    if_req[2] = 1'b0;
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h50;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wd_d_ready_busy", {31'd0, d_ready[2]}, 32'd0);
      chk("wd_mem_addr", mem_addr[2], 32'h30);
      cyc();
    end
    d_req[2] = 1'b0;
    en_cnt  = 0;
    rdy_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      en_cnt  += int'(mem_en[2]);
      rdy_cnt += int'(d_ready[2]);
      cyc();
    end
    chk("wd_no_mem_en", en_cnt, 32'd0);
    chk("wd_no_ready", rdy_cnt, 32'd0);

    repeat (3) cyc();
    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
